// File: rtl/valu_dispatch.sv
// Vector ALU dispatcher: in-order instruction FIFO, NREG x 64-bit register file and an
// IDLE/ISSUE/WAIT sequencer that drives an external ALU and gives up on a hung one.
module valu_dispatch #(
    parameter int DEPTH   = 4,
    parameter int NREG    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [1:0]  in_sew,
    input  logic [2:0]  in_vd,
    input  logic [2:0]  in_vs1,
    input  logic [2:0]  in_vs2,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [2:0]  ld_addr,
    input  logic [63:0] ld_data,
    input  logic [2:0]  rd_addr,
    output logic [63:0] rd_data,
    output logic [1:0]  alu_op,
    output logic [1:0]  alu_sew,
    output logic [63:0] alu_vs1_data,
    output logic [63:0] alu_vs2_data,
    output logic        alu_valid_in,
    input  logic        alu_valid_out,
    input  logic [63:0] alu_result,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] retire_cnt
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int WCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] sew;
        logic [2:0] vd;
        logic [2:0] vs1;
        logic [2:0] vs2;
    } instr_t;

    state_t         state_q, state_d;
    instr_t         fifo_q [DEPTH];
    instr_t         fifo_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [63:0]    vrf_q [NREG];
    logic [63:0]    vrf_d [NREG];
    logic [1:0]     op_q, op_d;
    logic [1:0]     sew_q, sew_d;
    logic [2:0]     vd_q, vd_d;
    logic [63:0]    vs1_data_q, vs1_data_d;
    logic [63:0]    vs2_data_q, vs2_data_d;
    logic           valid_in_q, valid_in_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           timeout_err_q, timeout_err_d;
    logic [15:0]    retire_cnt_q, retire_cnt_d;

    logic   push, pop, wb_en, ld_en;
    instr_t head;

    assign in_ready = (count_q != CW'(DEPTH));
    assign ld_ready = !((state_q == WAIT) && alu_valid_out);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == IDLE) && (count_q != '0);
    assign wb_en    = (state_q == WAIT) && alu_valid_out;
    assign ld_en    = ld_valid && ld_ready;
    assign head     = fifo_q[rd_ptr_q];

    assign rd_data      = vrf_q[rd_addr];
    assign alu_op       = op_q;
    assign alu_sew      = sew_q;
    assign alu_vs1_data = vs1_data_q;
    assign alu_vs2_data = vs2_data_q;
    assign alu_valid_in = valid_in_q;
    assign busy         = (state_q != IDLE) || (count_q != '0);
    assign timeout_err  = timeout_err_q;
    assign retire_cnt   = retire_cnt_q;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block leaves a signal
        // unassigned; skipping this default is what turns a next-state block into latches.
        state_d       = state_q;
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        vrf_d         = vrf_q;
        op_d          = op_q;
        sew_d         = sew_q;
        vd_d          = vd_q;
        vs1_data_d    = vs1_data_q;
        vs2_data_d    = vs2_data_q;
        valid_in_d    = 1'b0;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        retire_cnt_d  = retire_cnt_q;

        if (push) begin
            fifo_d[wr_ptr_q] = '{op: in_op, sew: in_sew, vd: in_vd, vs1: in_vs1, vs2: in_vs2};
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    // Operands come from the pre-edge file: no bypass of a same-cycle write.
                    op_d       = head.op;
                    sew_d      = head.sew;
                    vd_d       = head.vd;
                    vs1_data_d = vrf_q[head.vs1];
                    vs2_data_d = vrf_q[head.vs2];
                    valid_in_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (alu_valid_out) begin
                    retire_cnt_d = retire_cnt_q + 16'd1;
                    state_d      = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                    if (wait_cnt_d == WCW'(TIMEOUT)) begin
                        timeout_err_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A writeback wins the single write port; ld_ready already refuses the load.
        if (wb_en) begin
            vrf_d[vd_q] = alu_result;
        end else if (ld_en) begin
            vrf_d[ld_addr] = ld_data;
        end
    end

    // NOTE: state is updated with <= only, so every flop samples pre-edge values
    // regardless of statement order; blocking writes here would create ordering races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            op_q          <= '0;
            sew_q         <= '0;
            vd_q          <= '0;
            vs1_data_q    <= '0;
            vs2_data_q    <= '0;
            valid_in_q    <= 1'b0;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            retire_cnt_q  <= '0;
            for (int i = 0; i < NREG; i++) begin
                vrf_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            op_q          <= op_d;
            sew_q         <= sew_d;
            vd_q          <= vd_d;
            vs1_data_q    <= vs1_data_d;
            vs2_data_q    <= vs2_data_d;
            valid_in_q    <= valid_in_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
            retire_cnt_q  <= retire_cnt_d;
            vrf_q         <= vrf_d;
        end
    end

    // NOTE: FIFO storage has no reset; an entry is only read once count_q says it was
    // written, so clearing it would cost reset fan-out for nothing.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_valu_dispatch.sv
// Self-checking bench for valu_dispatch: behavioural ALU responder plus a sequential
// register-file model that executes instructions in program order.
module tb_valu_dispatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = '0;
    logic [1:0]  in_sew = '0;
    logic [2:0]  in_vd = '0;
    logic [2:0]  in_vs1 = '0;
    logic [2:0]  in_vs2 = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [2:0]  ld_addr = '0;
    logic [63:0] ld_data = '0;
    logic [2:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  alu_op;
    logic [1:0]  alu_sew;
    logic [63:0] alu_vs1_data;
    logic [63:0] alu_vs2_data;
    logic        alu_valid_in;
    logic        alu_valid_out = 1'b0;
    logic [63:0] alu_result = '0;
    logic        busy;
    logic        timeout_err;
    logic [15:0] retire_cnt;

    valu_dispatch #(.DEPTH(4), .NREG(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_sew(in_sew),
        .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_op(alu_op), .alu_sew(alu_sew), .alu_vs1_data(alu_vs1_data),
        .alu_vs2_data(alu_vs2_data), .alu_valid_in(alu_valid_in),
        .alu_valid_out(alu_valid_out), .alu_result(alu_result),
        .busy(busy), .timeout_err(timeout_err), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference state
    logic [63:0] ref_vrf [8];
    logic [15:0] ref_retire = '0;
    logic        ref_timeout = 1'b0;

    // ALU responder controls
    int          alu_lat = 2;
    bit          alu_hang = 1'b0;
    bit          alu_glitch = 1'b0;
    bit          alu_pend = 1'b0;
    int          alu_cd = 0;
    logic [63:0] alu_res = '0;
    int          pulses = 0;

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Lane-wise ALU semantics; VMAC is a 32-bit dot product of the lanes, upper half zero.
    function automatic logic [63:0] alu_fn(input logic [1:0] op, input logic [1:0] sew,
                                           input logic [63:0] a, input logic [63:0] b);
        int w;
        logic [63:0] m, x, y, r, acc;
        w = (sew == 2'd0) ? 8 : (sew == 2'd1) ? 16 : 32;
        m = (64'd1 << w) - 64'd1;
        r = '0;
        acc = '0;
        for (int i = 0; i < 64 / w; i++) begin
            x = (a >> (i * w)) & m;
            y = (b >> (i * w)) & m;
            case (op)
                2'd0:    r |= ((x + y) & m) << (i * w);
                2'd1:    r |= ((x - y) & m) << (i * w);
                2'd2:    r |= ((x * y) & m) << (i * w);
                default: acc += x * y;
            endcase
        end
        if (op == 2'd3) r = {32'd0, acc[31:0]};
        return r;
    endfunction

    // ALU responder: captures on the start pulse, answers alu_lat WAIT cycles later.
    initial begin
        forever begin
            @(negedge clk);
            alu_valid_out = 1'b0;
            alu_result = rnd64();
            if (!rst_n) begin
                alu_pend = 1'b0;
            end else begin
                if (alu_pend) begin
                    alu_cd--;
                    if (alu_cd == 0) begin
                        alu_valid_out = 1'b1;
                        alu_result = alu_res;
                        alu_pend = 1'b0;
                    end
                end else if (alu_glitch && !alu_valid_in && $urandom_range(0, 3) == 0) begin
                    alu_valid_out = 1'b1;
                end
                if (alu_valid_in) begin
                    alu_res = alu_fn(alu_op, alu_sew, alu_vs1_data, alu_vs2_data);
                    alu_cd = alu_lat;
                    alu_pend = !alu_hang;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (alu_valid_in === 1'b1) pulses++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic model_exec(input logic [12:0] ins);
        logic [1:0] op, sew;
        logic [2:0] vd, vs1, vs2;
        {op, sew, vd, vs1, vs2} = ins;
        ref_vrf[vd] = alu_fn(op, sew, ref_vrf[vs1], ref_vrf[vs2]);
        ref_retire++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_vrf[i] = '0;
        ref_retire = '0;
        ref_timeout = 1'b0;
    endtask

    task automatic do_load(input int addr, input logic [63:0] data);
        ld_valid = 1'b1;
        ld_addr = 3'(addr);
        ld_data = data;
        step();
        ld_valid = 1'b0;
        ref_vrf[addr] = data;
    endtask

    task automatic push(input logic [12:0] ins);
        int n = 0;
        {in_op, in_sew, in_vd, in_vs1, in_vs2} = ins;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL push_accept: in_ready got %b required 1 within 200 cycles", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle: busy got %b required 0 within 400 cycles", tag, busy);
        end
    endtask

    task automatic check_vrf(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            vectors++;
            if (rd_data !== ref_vrf[i]) begin
                miscompares++;
                $display("FAIL %s vrf[%0d]: got %h required %h", tag, i, rd_data, ref_vrf[i]);
            end
        end
        step();
    endtask

    task automatic check_status(input string tag);
        vectors++;
        if ({retire_cnt, timeout_err} !== {ref_retire, ref_timeout}) begin
            miscompares++;
            $display("FAIL %s status: retire_cnt/timeout_err got %0d/%b required %0d/%b",
                     tag, retire_cnt, timeout_err, ref_retire, ref_timeout);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if ({in_ready, ld_ready, alu_valid_in, alu_op, alu_sew, busy, timeout_err, retire_cnt}
            !== {1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL %s ctrl: in_rdy=%b ld_rdy=%b vin=%b op=%0d sew=%0d busy=%b terr=%b ret=%0d required 1 1 0 0 0 0 0 0",
                     tag, in_ready, ld_ready, alu_valid_in, alu_op, alu_sew, busy, timeout_err, retire_cnt);
        end
        vectors++;
        if ({alu_vs1_data, alu_vs2_data} !== 128'd0) begin
            miscompares++;
            $display("FAIL %s alu_data: got %h %h required 0 0", tag, alu_vs1_data, alu_vs2_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        model_reset();
        check_reset_outputs("reset");
        check_vrf("reset");
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_vadd();
        int n = 0;
        do_load(1, 64'h0102030405060708);
        do_load(2, 64'h0101010101010101);
        pulses = 0;
        push({2'd0, 2'd0, 3'd3, 3'd1, 3'd2});
        while (retire_cnt === ref_retire && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL vadd_period: got %0d cycles required 4", n);
        end
        wait_idle("vadd");
        model_exec({2'd0, 2'd0, 3'd3, 3'd1, 3'd2});
        rd_addr = 3'd3;
        #1;
        vectors++;
        if (rd_data !== 64'h0203040506070809) begin
            miscompares++;
            $display("FAIL vadd_result: got %h required 0203040506070809", rd_data);
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL vadd_pulses: alu_valid_in pulses got %0d required 1", pulses);
        end
        check_status("vadd");
        check_vrf("vadd");
    endtask

    task automatic test_vsub();
        do_load(1, 64'h0000000100020003);
        do_load(2, 64'h0001000100010001);
        push({2'd1, 2'd1, 3'd4, 3'd1, 3'd2});
        wait_idle("vsub");
        model_exec({2'd1, 2'd1, 3'd4, 3'd1, 3'd2});
        rd_addr = 3'd4;
        #1;
        vectors++;
        if (rd_data !== 64'hFFFF000000010002) begin
            miscompares++;
            $display("FAIL vsub_result: got %h required ffff000000010002", rd_data);
        end
        check_status("vsub");
        check_vrf("vsub");
    endtask

    task automatic test_vmul_hold();
        logic [63:0] v1 = 64'h0000000300000002;
        logic [63:0] v2 = 64'h0000000500000007;
        int n = 0;
        do_load(1, v1);
        do_load(2, v2);
        alu_lat = 4;
        push({2'd2, 2'd2, 3'd5, 3'd1, 3'd2});
        do begin
            step();
            n++;
            vectors++;
            if ({alu_op, alu_sew, alu_vs1_data, alu_vs2_data} !== {2'd2, 2'd2, v1, v2}) begin
                miscompares++;
                $display("FAIL vmul_hold cycle %0d: op/sew/vs1/vs2 got %0d %0d %h %h required 2 2 %h %h",
                         n, alu_op, alu_sew, alu_vs1_data, alu_vs2_data, v1, v2);
            end
        end while (retire_cnt === ref_retire && n < 20);
        vectors++;
        if (n != 6) begin
            miscompares++;
            $display("FAIL vmul_latency: got %0d cycles to retire required 6", n);
        end
        alu_lat = 2;
        model_exec({2'd2, 2'd2, 3'd5, 3'd1, 3'd2});
        rd_addr = 3'd5;
        #1;
        vectors++;
        if (rd_data !== 64'h0000000F0000000E) begin
            miscompares++;
            $display("FAIL vmul_result: got %h required 0000000f0000000e", rd_data);
        end
        check_status("vmul");
        check_vrf("vmul");
    endtask

    task automatic test_collision();
        logic [63:0] ldv = rnd64();
        int n = 0;
        do_load(1, rnd64());
        do_load(2, rnd64());
        push({2'd0, 2'd1, 3'd6, 3'd1, 3'd2});
        while (alu_valid_out !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (alu_valid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL collision_strobe: alu_valid_out got %b required 1 within 20 cycles", alu_valid_out);
        end
        ld_valid = 1'b1;
        ld_addr = 3'd6;
        ld_data = ldv;
        #1;
        vectors++;
        if (ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL collision_ld_ready: got %b required 0", ld_ready);
        end
        step();
        model_exec({2'd0, 2'd1, 3'd6, 3'd1, 3'd2});
        rd_addr = 3'd6;
        #1;
        vectors++;
        if (rd_data !== ref_vrf[6]) begin
            miscompares++;
            $display("FAIL collision_wb: vrf[6] got %h required %h", rd_data, ref_vrf[6]);
        end
        vectors++;
        if (ld_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL collision_retry_ready: got %b required 1", ld_ready);
        end
        step();
        ld_valid = 1'b0;
        ref_vrf[6] = ldv;
        check_status("collision");
        check_vrf("collision");
    endtask

    task automatic test_timeout();
        logic [12:0] ins [5];
        for (int i = 0; i < 8; i++) do_load(i, rnd64());
        for (int i = 0; i < 5; i++) begin
            ins[i] = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
        end
        alu_hang = 1'b1;
        for (int i = 0; i < 5; i++) push(ins[i]);
        vectors++;
        if ({in_ready, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL timeout_full: in_ready/busy got %b/%b required 0/1", in_ready, busy);
        end
        for (int i = 0; i < 12; i++) step();
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: timeout_err got %b required 0 after 14 WAIT cycles", timeout_err);
        end
        step();
        ref_timeout = 1'b1;
        check_status("timeout_hit");
        rd_addr = ins[0][8:6];
        #1;
        vectors++;
        if (rd_data !== ref_vrf[ins[0][8:6]]) begin
            miscompares++;
            $display("FAIL timeout_nowrite: vrf[%0d] got %h required %h", ins[0][8:6], rd_data, ref_vrf[ins[0][8:6]]);
        end
        step();
        vectors++;
        if ({alu_valid_in, alu_op, alu_sew} !== {1'b1, ins[1][12:11], ins[1][10:9]}) begin
            miscompares++;
            $display("FAIL timeout_next_issue: vin/op/sew got %b/%0d/%0d required 1/%0d/%0d",
                     alu_valid_in, alu_op, alu_sew, ins[1][12:11], ins[1][10:9]);
        end
        alu_hang = 1'b0;
        wait_idle("timeout");
        for (int i = 2; i < 5; i++) model_exec(ins[i]);
        check_status("timeout_after");
        check_vrf("timeout");
    endtask

    task automatic test_random();
        logic [12:0] batch [$];
        logic [12:0] ins;
        int nb;
        alu_glitch = 1'b1;
        for (int b = 0; b < 10; b++) begin
            batch.delete();
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 1) == 1) do_load(i, rnd64());
            end
            alu_lat = $urandom_range(1, 3);
            nb = $urandom_range(1, 7);
            for (int k = 0; k < nb; k++) begin
                ins = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
                batch.push_back(ins);
                push(ins);
            end
            wait_idle("random");
            foreach (batch[k]) model_exec(batch[k]);
            check_status("random");
            check_vrf("random");
        end
        alu_glitch = 1'b0;
        alu_lat = 2;
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 8; i++) do_load(i, rnd64());
        alu_hang = 1'b1;
        push({2'd0, 2'd0, 3'd7, 3'd1, 3'd2});
        push({2'd1, 2'd0, 3'd6, 3'd1, 3'd2});
        step();
        step();
        rst_n = 1'b0;
        step();
        model_reset();
        check_reset_outputs("mid_wait_reset");
        check_vrf("mid_wait_reset");
        alu_hang = 1'b0;
        do_load(1, 64'h1111111111111111);
        vectors++;
        if (retire_cnt !== 16'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: retire_cnt/busy got %0d/%b required 0/0", retire_cnt, busy);
        end
        ref_vrf[1] = '0;
        {in_op, in_sew, in_vd, in_vs1, in_vs2} = {2'd0, 2'd0, 3'd2, 3'd0, 3'd0};
        in_valid = 1'b1;
        rst_n = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL first_push: busy got %b required 1 after first post-reset push", busy);
        end
        wait_idle("post_reset");
        model_exec({2'd0, 2'd0, 3'd2, 3'd0, 3'd0});
        check_status("post_reset");
        check_vrf("post_reset");
    endtask

    initial begin
        test_reset();
        test_vadd();
        test_vsub();
        test_vmul_hold();
        test_collision();
        test_timeout();
        test_random();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
